// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and flag vector layout.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } state_t;

    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_SIGN  = 1;
    localparam int unsigned FLG_CARRY = 2;
    localparam int unsigned FLG_OVF   = 3;
    localparam int unsigned FLG_DIV0  = 4;
    localparam int unsigned FLG_N     = 5;

    function automatic logic [FLG_N-1:0] make_flags(
        input logic zero,
        input logic sign,
        input logic carry,
        input logic ovf,
        input logic div0
    );
        logic [FLG_N-1:0] f;
        f            = '0;
        f[FLG_ZERO]  = zero;
        f[FLG_SIGN]  = sign;
        f[FLG_CARRY] = carry;
        f[FLG_OVF]   = ovf;
        f[FLG_DIV0]  = div0;
        return f;
    endfunction

endpackage

// File: rtl/addsub_nbit.sv
// WIDTH-bit adder/subtractor; o_carry is carry-out on add and borrow (a<b unsigned) on subtract.
module addsub_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum   = w_full[WIDTH-1:0];
    assign o_carry = i_sub ? ~w_full[WIDTH] : w_full[WIDTH];
    assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_seq_nbit.sv
// Accumulator-CPU ALU: single-cycle arithmetic/logic ops, multi-cycle shift-add MUL and restoring DIV
// sharing one adder, with a start/busy/done handshake and flags written only on completion.
module alu_seq_nbit
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             div0_flag
);

    state_t             r_state, w_nxt_state;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [WIDTH-1:0]   r_hi, w_nxt_hi;
    logic [WIDTH-1:0]   r_lo, w_nxt_lo;
    logic [WIDTH-1:0]   r_opb, w_nxt_opb;
    logic [WIDTH-1:0]   r_res_lo, w_nxt_res_lo;
    logic [WIDTH-1:0]   r_res_hi, w_nxt_res_hi;
    logic [FLG_N-1:0]   r_flags, w_nxt_flags;
    logic               r_done, w_nxt_done;

    logic [WIDTH-1:0]   w_add_a, w_add_b, w_sum;
    logic               w_add_sub, w_carry, w_ovf;
    logic [WIDTH-1:0]   w_logic;
    logic [WIDTH-1:0]   w_shift_rem;
    logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_rem, w_div_quo;
    logic               w_last;

    addsub_nbit #(.WIDTH(WIDTH)) u_addsub (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .i_sub   (w_add_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry),
        .o_ovf   (w_ovf)
    );

    // Adder operand mux depends only on registered state and inputs, never on adder outputs.
    always_comb begin
        w_add_a   = a;
        w_add_b   = b;
        w_add_sub = (op != OP_ADD);
        case (r_state)
            ST_MUL_RUN: begin
                w_add_a   = r_hi;
                w_add_b   = r_lo[0] ? r_opb : '0;
                w_add_sub = 1'b0;
            end
            ST_DIV_RUN: begin
                w_add_a   = w_shift_rem;
                w_add_b   = r_opb;
                w_add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_logic = '0;
        case (op)
            OP_AND:  w_logic = a & b;
            OP_OR:   w_logic = a | b;
            default: w_logic = a ^ b;
        endcase
    end

    assign w_shift_rem = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_mul_hi    = {w_carry, w_sum[WIDTH-1:1]};
    assign w_mul_lo    = {w_sum[0], r_lo[WIDTH-1:1]};
    // A set remainder MSB means the shifted value exceeds any WIDTH-bit divisor, so the
    // trial subtract succeeds regardless of the truncated borrow.
    assign w_div_ok    = r_hi[WIDTH-1] | ~w_carry;
    assign w_div_rem   = w_div_ok ? w_sum : w_shift_rem;
    assign w_div_quo   = {r_lo[WIDTH-2:0], w_div_ok};
    assign w_last      = (r_cnt == CNT_W'(1));

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_hi     = r_hi;
        w_nxt_lo     = r_lo;
        w_nxt_opb    = r_opb;
        w_nxt_res_lo = r_res_lo;
        w_nxt_res_hi = r_res_hi;
        w_nxt_flags  = r_flags;
        w_nxt_done   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            w_nxt_res_lo = w_sum;
                            w_nxt_res_hi = '0;
                            w_nxt_flags  = make_flags(w_sum == '0, w_sum[WIDTH-1], w_carry, w_ovf, 1'b0);
                            w_nxt_done   = 1'b1;
                        end
                        OP_CMP: begin
                            w_nxt_flags  = make_flags(w_sum == '0, w_sum[WIDTH-1], w_carry, w_ovf, 1'b0);
                            w_nxt_done   = 1'b1;
                        end
                        OP_AND, OP_OR, OP_XOR: begin
                            w_nxt_res_lo = w_logic;
                            w_nxt_res_hi = '0;
                            w_nxt_flags  = make_flags(w_logic == '0, w_logic[WIDTH-1], 1'b0, 1'b0, 1'b0);
                            w_nxt_done   = 1'b1;
                        end
                        OP_MUL: begin
                            w_nxt_hi    = '0;
                            w_nxt_lo    = a;
                            w_nxt_opb   = b;
                            w_nxt_cnt   = CNT_W'(WIDTH);
                            w_nxt_state = ST_MUL_RUN;
                        end
                        default: begin
                            if (b == '0) begin
                                w_nxt_res_lo = '1;
                                w_nxt_res_hi = a;
                                w_nxt_flags  = make_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                                w_nxt_done   = 1'b1;
                            end else begin
                                w_nxt_hi    = '0;
                                w_nxt_lo    = a;
                                w_nxt_opb   = b;
                                w_nxt_cnt   = CNT_W'(WIDTH);
                                w_nxt_state = ST_DIV_RUN;
                            end
                        end
                    endcase
                end
            end
            ST_MUL_RUN: begin
                w_nxt_hi  = w_mul_hi;
                w_nxt_lo  = w_mul_lo;
                w_nxt_cnt = r_cnt - CNT_W'(1);
                if (w_last) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_res_hi = w_mul_hi;
                    w_nxt_res_lo = w_mul_lo;
                    w_nxt_flags  = make_flags({w_mul_hi, w_mul_lo} == '0, w_mul_hi[WIDTH-1],
                                              w_mul_hi != '0, 1'b0, 1'b0);
                    w_nxt_done   = 1'b1;
                end
            end
            ST_DIV_RUN: begin
                w_nxt_hi  = w_div_rem;
                w_nxt_lo  = w_div_quo;
                w_nxt_cnt = r_cnt - CNT_W'(1);
                if (w_last) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_res_hi = w_div_rem;
                    w_nxt_res_lo = w_div_quo;
                    w_nxt_flags  = make_flags(w_div_quo == '0, w_div_quo[WIDTH-1], 1'b0, 1'b0, 1'b0);
                    w_nxt_done   = 1'b1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_hi     <= w_nxt_hi;
            r_lo     <= w_nxt_lo;
            r_opb    <= w_nxt_opb;
            r_res_lo <= w_nxt_res_lo;
            r_res_hi <= w_nxt_res_hi;
            r_flags  <= w_nxt_flags;
            r_done   <= w_nxt_done;
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign result_lo  = r_res_lo;
    assign result_hi  = r_res_hi;
    assign zero_flag  = r_flags[FLG_ZERO];
    assign sign_flag  = r_flags[FLG_SIGN];
    assign carry_flag = r_flags[FLG_CARRY];
    assign ovf_flag   = r_flags[FLG_OVF];
    assign div0_flag  = r_flags[FLG_DIV0];

endmodule
